// File: rtl/comp_pkg.sv
// Shared types and defaults for the chunked sequential magnitude comparator.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;

  // Width of the chunk index; a single-chunk build still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module comp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/comp_seq_nb.sv
// Sequential MSB-first comparator: one CHUNK slice per cycle, stops at the first unequal slice.
module comp_seq_nb
  import comp_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CHUNK       = CHUNK_DEF,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_bits(NCHUNK);

  if (WIDTH < 4 || WIDTH > 64 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("comp_seq_nb: WIDTH must be 4..64 and a multiple of CHUNK");
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so it is applied once at latch time and only ever affects chunk 0.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    SIGNED_MODE ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CHUNK-1:0] a_ch [NCHUNK];
  logic [CHUNK-1:0] b_ch [NCHUNK];
  logic [CHUNK-1:0] a_c, b_c;
  logic             gt, lt, last, load, done_nxt;
  logic             aeb_nxt, agb_nxt, alb_nxt;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
    assign a_ch[i] = a_q[WIDTH-1-i*CHUNK -: CHUNK];
    assign b_ch[i] = b_q[WIDTH-1-i*CHUNK -: CHUNK];
  end

  always_comb begin
    a_c = a_ch[0];
    b_c = b_ch[0];
    for (int i = 1; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_c = a_ch[i];
        b_c = b_ch[i];
      end
    end
  end

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_c),
    .y  (b_c),
    .gt (gt),
    .lt (lt)
  );

  assign last = (idx == IW'(NCHUNK - 1));
  assign busy = (state == CMP);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    done_nxt  = 1'b0;
    aeb_nxt   = aeb;
    agb_nxt   = agb;
    alb_nxt   = alb;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CMP;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      CMP: begin
        if (gt || lt) begin
          aeb_nxt   = 1'b0;
          agb_nxt   = gt;
          alb_nxt   = lt;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (last) begin
          aeb_nxt   = 1'b1;
          agb_nxt   = 1'b0;
          alb_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      done  <= 1'b0;
      aeb   <= 1'b0;
      agb   <= 1'b0;
      alb   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load) begin
        a_q <= a ^ SIGN_MASK;
        b_q <= b ^ SIGN_MASK;
      end
      done <= done_nxt;
      aeb  <= aeb_nxt;
      agb  <= agb_nxt;
      alb  <= alb_nxt;
    end
  end

endmodule

// File: tb/tb_comp_seq_nb.sv
// Bench for comp_seq_nb: six parameter builds exercised in turn against an arithmetic reference.
module tb_comp_seq_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cfg_w(input int g);
    case (g)
      0, 1:    return 16;
      2, 3:    return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_c(input int g);
    case (g)
      0, 1:    return 4;
      2, 3:    return 8;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < 6; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int C = cfg_c(g);
    localparam int S = g % 2;
    localparam int N = W / C;

    logic         rst_n, start, busy, done, aeb, agb, alb;
    logic [W-1:0] a, b;
    logic [2:0]   last_flags;

    comp_seq_nb #(.WIDTH(W), .CHUNK(C), .SIGNED_MODE(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .aeb   (aeb),
      .agb   (agb),
      .alb   (alb)
    );

    function automatic string tg(input string s);
      return $sformatf("w%0d_c%0d_s%0d_%s", W, C, S, s);
    endfunction

    // Flags {aeb,agb,alb} from integer values; latency from the top differing bit.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [2:0] fl, output int lat);
      longint       va, vb;
      logic [W-1:0] d;
      va = longint'(av);
      vb = longint'(bv);
      if (S != 0) begin
        if (av[W-1]) va = va - (longint'(1) << W);
        if (bv[W-1]) vb = vb - (longint'(1) << W);
      end
      fl  = (va == vb) ? 3'b100 : (va > vb) ? 3'b010 : 3'b001;
      d   = av ^ bv;
      lat = N;
      for (int i = 0; i < W; i++)
        if (d[i]) lat = (W - 1 - i) / C + 1;
    endfunction

    function automatic logic [W-1:0] rnd();
      return W'({$urandom, $urandom});
    endfunction

    // Called at a negedge with the DUT expected idle; returns at the negedge of the done cycle.
    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
      logic [2:0] ef;
      int         el, lat;
      bit         got;
      model(av, bv, ef, el);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clk);
      @(negedge clk);
      check(tg("accept"), {busy, done, aeb, agb, alb}, {1'b1, 1'b0, last_flags});
      if (!hold) start = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < N + 2) begin
        a = rnd();
        b = rnd();
        @(posedge clk);
        @(negedge clk);
        lat++;
        if (done) got = 1'b1;
        else check(tg("hold"), {busy, aeb, agb, alb}, {1'b1, last_flags});
      end
      check(tg("done_seen"), 64'(got), 64'd1);
      check(tg("latency"), 64'(lat), 64'(el));
      check(tg("flags"), {busy, aeb, agb, alb}, {1'b0, ef});
      last_flags = ef;
    endtask

    task automatic reset_mid();
      logic [W-1:0] v;
      bit           saw_done;
      v     = rnd();
      start = 1'b1;
      a     = v;
      b     = v;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check(tg("rst_async"), {busy, done, aeb, agb, alb}, 5'b0);
      saw_done = 1'b0;
      repeat (N + 1) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      check(tg("rst_quiet"), 64'(saw_done), 64'd0);
      rst_n      = 1'b1;
      last_flags = 3'b000;
    endtask

    task automatic run_all();
      logic [W-1:0] x, y, one;
      int           kind;
      bit           hold;
      one        = W'(1);
      start      = 1'b0;
      a          = '0;
      b          = '0;
      rst_n      = 1'b1;
      last_flags = 3'b000;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check(tg("reset"), {busy, done, aeb, agb, alb}, 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      do_cmp(W'(64'h1234), W'(64'h1234), 1'b0);
      do_cmp(W'(64'h8000), W'(64'h7FFF), 1'b0);
      do_cmp(W'(64'h1235), W'(64'h1236), 1'b1);
      do_cmp(W'(64'hFFFF), W'(64'h0001), 1'b1);
      do_cmp({W{1'b1}}, one, 1'b1);
      start = 1'b0;
      @(negedge clk);
      check(tg("idle_after"), {busy, done, aeb, agb, alb}, {2'b00, last_flags});
      reset_mid();
      do_cmp(W'(64'h1234), W'(64'h1234), 1'b0);
      for (int n = 0; n < 30; n++) begin
        kind = $urandom_range(0, 2);
        hold = 1'($urandom_range(0, 1));
        x    = rnd();
        case (kind)
          0:       y = x;
          1:       y = x ^ (one << $urandom_range(0, W - 1));
          default: y = rnd();
        endcase
        do_cmp(x, y, hold);
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b0;
          @(negedge clk);
          check(tg("gap_idle"), {busy, done, aeb, agb, alb}, {2'b00, last_flags});
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      start = 1'b0;
      @(negedge clk);
    endtask
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    g_cfg[0].run_all();
    g_cfg[1].run_all();
    g_cfg[2].run_all();
    g_cfg[3].run_all();
    g_cfg[4].run_all();
    g_cfg[5].run_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_seq_nb.md
COMP_SEQ_NB -- requirements
Module: comp_seq_nb

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; legal values 4..64.
REQ-002 Parameter: CHUNK, 4, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 Parameter: SIGNED_MODE, 0, 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: start  input  1  request a compare; accepted only when busy=0.
REQ-007 Port: a  input  WIDTH  operand A; sampled only at the accepting edge.
REQ-008 Port: b  input  WIDTH  operand B; sampled only at the accepting edge.
REQ-009 Port: busy  output  1  compare in progress.
REQ-010 Port: done  output  1  one-cycle pulse; result flags valid from this cycle.
REQ-011 Port: aeb  output  1  registered result, a == b.
REQ-012 Port: agb  output  1  registered result, a > b.
REQ-013 Port: alb  output  1  registered result, a < b.

Function
REQ-014 NCHUNK = WIDTH/CHUNK; chunk 0 = most-significant CHUNK bits.
REQ-015 FSM states: IDLE (busy=0) and CMP (busy=1); no other reachable states.
REQ-016 IDLE -> CMP when start=1 at a rising edge; a, b latched into internal registers, chunk index cleared to 0.
REQ-017 start=1 while in CMP SHALL be ignored; latched operands and progress unaffected.
REQ-018 In CMP, each cycle compares chunk[idx] of the latched operands, MSB-first.
REQ-019 Chunks unequal at idx=j -> at that edge: flags written (exactly one of agb/alb = 1, aeb=0), done=1, FSM -> IDLE (early termination).
REQ-020 All chunks equal -> at the edge evaluating idx=NCHUNK-1: aeb=1, agb=0, alb=0, done=1, FSM -> IDLE.
REQ-021 Latency: start edge to done edge = j+1 cycles on early termination; NCHUNK cycles when equal; never more than NCHUNK.
REQ-022 SIGNED_MODE=1: sign bit of both operands inverted before chunk 0 compare; other chunks unsigned.
REQ-023 Flags SHALL be one-hot after the first done and hold their value until the next done; they never change while busy=1.
REQ-024 done high for exactly one cycle per accepted start; busy falls on the same edge done rises.
REQ-025 start=1 in the done cycle (busy=0) SHALL be accepted: back-to-back compares with no idle cycle.
REQ-026 Input a/b changes during CMP SHALL NOT affect the in-flight result.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, busy=0, done=0, aeb=0, agb=0, alb=0, idx=0, operand registers 0.
REQ-028 Reset during CMP aborts the compare; no done pulse is produced for it.
REQ-029 First start is accepted at the first rising edge with rst_n=1.

Structure
REQ-030 Shared package comp_pkg holds the FSM state type (IDLE, CMP) and the parameter defaults (WIDTH=16, CHUNK=4).
REQ-031 One sub-module comp_chunk: combinational CHUNK-bit compare producing gt and lt; instantiated once, fed by an idx-selected slice.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 Unsigned a=16'h1234, b=16'h1234 -> done 4 cycles after start, aeb=1, agb=0, alb=0.
REQ-033 Unsigned a=16'h8000, b=16'h7FFF -> done 1 cycle after start, agb=1; a=16'h1235, b=16'h1236 -> done after 4 cycles, alb=1.
REQ-034 SIGNED_MODE=1, a=16'hFFFF (-1), b=16'h0001 -> alb=1 after 1 cycle; unsigned build with same operands -> agb=1.
REQ-035 start held high continuously with a/b toggling mid-compare -> each result matches operands sampled at its accepting edge; done pulses back-to-back with no gap.
REQ-036 rst_n pulled low at cycle 2 of a 4-cycle compare -> all outputs 0 immediately, no done; next start after release completes normally.
REQ-037 Random sweep, WIDTH=32/CHUNK=8 and WIDTH=8/CHUNK=1, both signed modes -> flags match reference model, one-hot, latency <= NCHUNK.
